// File: rtl/alu_pkg.sv
// Shared opcode, flag-select and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] FS_GT   = 2'b00;
  localparam logic [1:0] FS_EQ   = 2'b01;
  localparam logic [1:0] FS_AZ   = 2'b10;
  localparam logic [1:0] FS_EVEN = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles.
// done and product are combinational so the parent can register the final sum on the last edge.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with operand registers and a start/busy/done handshake.
// Single-cycle ops finish on the start edge; MUL runs through alu_seq_mul.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 load_a,
  input  logic                 load_b,
  input  logic [2:0]           op,
  input  logic [1:0]           flag_sel,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag,
  output logic                 ovf,
  output logic                 zero
);

  localparam int RW = 2 * WIDTH;

  state_t             state;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   a_w, b_w;
  logic [1:0]         fs_w;
  logic [RW-1:0]      a_ext, b_ext, alu_res, fin_res;
  logic               fin_flag;
  logic               launch_mul;
  logic               mul_busy, mul_done;
  logic [RW-1:0]      mul_product;

  function automatic logic flag_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] fs);
    logic f;
    case (fs)
      FS_GT:   f = (a > b);
      FS_EQ:   f = (a == b);
      FS_AZ:   f = (a == '0);
      default: f = ~a[0];
    endcase
    return f;
  endfunction

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  // NOTE: assign a default before the case so no path leaves alu_res unassigned (no latch).
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_SHR:  alu_res = a_ext >> 1;
      OP_SHL:  alu_res = a_ext << 1;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      default: alu_res = '0;
    endcase
  end

  // In MUL the flag comes from the snapshot, since A/B may be reloaded mid-operation.
  assign fin_res    = (state == ST_MUL) ? mul_product : alu_res;
  assign fin_flag   = (state == ST_MUL) ? flag_fn(a_w, b_w, fs_w) : flag_fn(a_q, b_q, flag_sel);
  assign launch_mul = (state == ST_IDLE) && start && (op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (launch_mul),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // NOTE: non-blocking assignments mean a start in the same cycle as a load sees the old A/B.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      a_w    <= '0;
      b_w    <= '0;
      fs_w   <= '0;
      result <= '0;
      flag   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_a) a_q <= din;
          if (load_b) b_q <= din;
          if (start) begin
            a_w  <= a_q;
            b_w  <= b_q;
            fs_w <= flag_sel;
            if (op == OP_MUL) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              result <= fin_res;
              flag   <= fin_flag;
              ovf    <= |fin_res[RW-1:WIDTH];
              zero   <= ~|fin_res;
              done   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result <= fin_res;
            flag   <= fin_flag;
            ovf    <= |fin_res[RW-1:WIDTH];
            zero   <= ~|fin_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (!mul_busy) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8) with a result scoreboard popped on each done pulse.
module tb_alu_seq_core;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] result;
    logic           flag;
    logic           ovf;
    logic           zero;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           load_a, load_b;
  logic [2:0]     op;
  logic [1:0]     flag_sel;
  logic           start;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           flag, ovf, zero;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   a_m      = 0;
  int   b_m      = 0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .load_a   (load_a),
    .load_b   (load_b),
    .op       (op),
    .flag_sel (flag_sel),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag     (flag),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [1:0] fs, input int a, input int b);
    int   r;
    exp_t e;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SHR:  r = a / 2;
      OP_SHL:  r = a * 2;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a * b;
    endcase
    e.result = r[2*W-1:0];
    e.ovf    = (e.result[2*W-1:W] != 0);
    e.zero   = (e.result == 0);
    case (fs)
      FS_GT:   e.flag = (a > b);
      FS_EQ:   e.flag = (a == b);
      FS_AZ:   e.flag = (a == 0);
      default: e.flag = (a % 2 == 0);
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.result));
        check("flag",   32'(flag),   32'(e.flag));
        check("ovf",    32'(ovf),    32'(e.ovf));
        check("zero",   32'(zero),   32'(e.zero));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit la, input bit lb, input logic [W-1:0] v);
    load_a = la;
    load_b = lb;
    din    = v;
    tick();
    load_a = 1'b0;
    load_b = 1'b0;
    if (la) a_m = int'(v);
    if (lb) b_m = int'(v);
  endtask

  task automatic issue(input logic [2:0] o, input logic [1:0] fs, input bit expect_done);
    op       = o;
    flag_sel = fs;
    start    = 1'b1;
    if (expect_done) sb.push_back(model(o, fs, a_m, b_m));
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_flag"},   32'(flag),   32'd0);
    check({tag, "_ovf"},    32'(ovf),    32'd0);
    check({tag, "_zero"},   32'(zero),   32'd0);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst_n is an active-high reset despite its name.
    rst_n = 1'b1; din = '0; load_a = 1'b0; load_b = 1'b0;
    op = OP_ADD; flag_sel = FS_GT; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b0;
    tick();

    // ADD with carry into result[W]
    load(1, 0, 8'd200);
    load(0, 1, 8'd100);
    issue(OP_ADD, FS_GT, 1);
    check("add_done",       32'(done), 32'd1);
    check("add_busy",       32'(busy), 32'd0);
    tick();
    check("add_done_pulse", 32'(done), 32'd0);

    // SUB underflow sign-extends into the upper half
    load(1, 0, 8'd5);
    load(0, 1, 8'd7);
    issue(OP_SUB, FS_GT, 1);
    drain("sub_drain", 4);

    // MUL 255*255 via simultaneous A/B load; start and load during busy are ignored
    load(1, 1, 8'd255);
    issue(OP_MUL, FS_EQ, 1);
    for (int i = 0; i < W; i++) begin
      check("mul_busy",    32'(busy), 32'd1);
      check("mul_no_done", 32'(done), 32'd0);
      if (i == 3) begin
        op = OP_ADD; start = 1'b1; load_a = 1'b1; din = 8'd0;
      end
      tick();
      start = 1'b0; load_a = 1'b0;
    end
    check("mul_done",       32'(done), 32'd1);
    check("mul_busy_clear", 32'(busy), 32'd0);
    tick();
    check("mul_done_pulse", 32'(done), 32'd0);
    repeat (3) tick();

    // A must still be 255: the busy-time load was dropped
    load(0, 1, 8'h0F);
    issue(OP_AND, FS_AZ, 1);
    drain("and_drain", 4);

    // Shifts
    load(1, 0, 8'h81);
    issue(OP_SHL, FS_EVEN, 1);
    issue(OP_SHR, FS_EVEN, 1);
    drain("shift_drain", 4);

    // XOR with a same-cycle load, then back-to-back ops in the done cycle
    load(1, 1, 8'h3C);
    load_a = 1'b1; din = 8'h11;
    issue(OP_XOR, FS_EQ, 1);
    load_a = 1'b0;
    a_m = 8'h11;
    check("xor_done", 32'(done), 32'd1);
    issue(OP_ADD, FS_GT, 1);
    issue(OP_OR, FS_AZ, 1);
    drain("b2b_drain", 4);

    // Largest ADD and zero-operand MUL
    load(1, 1, 8'd255);
    issue(OP_ADD, FS_EVEN, 1);
    drain("addmax_drain", 4);
    load(1, 0, 8'd0);
    load(0, 1, 8'd200);
    issue(OP_MUL, FS_AZ, 1);
    drain("mulzero_drain", 2 * W);

    // Reset during MUL aborts with no done
    load(1, 0, 8'd15);
    load(0, 1, 8'd17);
    issue(OP_MUL, FS_GT, 0);
    repeat (3) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) tick();
    check("abort_hold_done", 32'(done), 32'd0);
    rst_n = 1'b0;
    a_m = 0;
    b_m = 0;
    tick();
    repeat (W + 2) tick();
    check("abort_no_late_done", 32'(sb.size()), 32'd0);

    // MUL 15*17 after reset
    load(1, 0, 8'd15);
    load(0, 1, 8'd17);
    issue(OP_MUL, FS_GT, 1);
    repeat (W - 1) tick();
    check("mul2_busy_last", 32'(busy), 32'd1);
    tick();
    check("mul2_done",      32'(done), 32'd1);
    drain("final_drain", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, registered successor to the 8-bit Tiny Tapeout ALU. Operand registers A and B load from a shared input bus, and a start/busy/done handshake launches each operation. Every result is registered. Multiply runs as an iterative shift-add over WIDTH cycles, so the combinational WIDTH×WIDTH multiplier is gone. The block sits between the pad-level input bus and the output/bidirectional pins of the top-level wrapper.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; legal range 4 to 32; result width is 2·WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active-high. The port name is kept for wrapper pin compatibility.
- din  in  WIDTH  operand input bus.
- load_a  in  1  capture din into A on the clock edge.
- load_b  in  1  capture din into B on the clock edge.
- op  in  3  opcode, sampled with start.
- flag_sel  in  2  flag function, sampled with start.
- start  in  1  launch the operation; accepted only in IDLE.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result and flags update.
- result  out  2·WIDTH  registered result.
- flag  out  1  registered compare flag.
- ovf  out  1  registered; equals result[2W-1:W] != 0.
- zero  out  1  registered; equals result == 0.

## Operation
- Reset clears A, B, result, flag, ovf, zero, busy and done. Reset forces state to IDLE.
- Operand loading:
  - load_a and load_b are honoured only in IDLE.
  - Both high together loads the same din into A and B.
  - Loads while busy are ignored.
- Start:
  - In IDLE, start snapshots A, B, op and flag_sel into internal working registers.
  - Later loads do not affect the operation in flight.
  - If load and start occur in the same cycle, start uses the old A/B values.
- Opcodes (W = WIDTH, results zero-extended to 2W unless noted):
  - 000 ADD: A+B; the carry appears in result[W].
  - 001 SUB: A−B in 2W-bit two's complement. The upper half is all ones when A<B.
  - 010 SHR: A>>1 (logical).
  - 011 SHL: A<<1, 2W wide, so A[W-1] lands in result[W].
  - 100 AND, 101 OR, 110 XOR: bitwise A op B.
  - 111 MUL: unsigned A·B, iterative.
- flag_sel:
  - 00: A>B (unsigned).
  - 01: A==B.
  - 10: A==0.
  - 11: A[0]==0 (A is even).
  - The flag is computed from the snapshot operands.
- State machine:
  - IDLE, start, op≠111: go to IDLE. result, flags and done update at the same edge.
  - IDLE, start, op=111: go to MUL with counter=0.
  - MUL: each edge adds the shifted multiplicand if the current multiplier bit is 1, then increments the counter.
  - MUL, counter=W−1: the final accumulate writes result, flags and done, and the state returns to IDLE.
- start while busy is ignored and is not queued.
- result holds its value until the next completed operation.

## Timing
- Single-cycle ops: start sampled at edge k; result and done valid after edge k; latency 1.
- MUL: start at edge k; busy high after edges k through k+W−1; result and done valid after edge k+W; latency W.
- done is high for exactly one cycle. busy is low in the done cycle.
- Back-to-back ops: a new start is legal in the done cycle.
- Reset asserted mid-MUL: the operation aborts immediately (asynchronous reset). No done pulse is produced and all outputs read 0.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams OP_ADD … OP_MUL.
  - Flag-select localparams FS_GT, FS_EQ, FS_AZ, FS_EVEN.
  - FSM state encoding ST_IDLE, ST_MUL.
- One sub-module, alu_seq_mul:
  - Iterative shift-add multiplier, parametrised by WIDTH.
  - Ports: start, a, b, busy, done, product.
  - The top-level FSM instantiates it and muxes its product into result.
- Flag logic and the single-cycle ops live in the top-level file.

## Test plan (WIDTH=8)
- Load A=200, B=100; ADD → 1 cycle later result=0x012C, ovf=1, zero=0, done for one cycle.
- A=5, B=7, SUB with flag_sel=00 → result=0xFFFE, ovf=1, flag=0.
- A=255, B=255, MUL → busy for 8 cycles; result=0xFE01 with done on the 8th edge after start. A second start during busy is ignored, with no extra done.
- A=0x81, SHL → result=0x0102, ovf=1. Then SHR → result=0x0040, ovf=0. With flag_sel=11 and A=0x81, flag=0.
- A=B=0x3C, XOR with flag_sel=01 → result=0, zero=1, flag=1. Also issue load_a=0x11 together with start: the op uses 0x3C, and A reads 0x11 afterwards.
- Start MUL 15·17, assert reset on cycle 4 → all outputs are 0 immediately and no done pulse appears. After release, MUL 15·17 gives 0x00FF after 8 cycles.
